// File: rtl/eq_mac_sched_pkg.sv
// eq_mac_sched_pkg: shared constants, FSM state type and saturation/gain helpers
//   for the time-shared EQ/volume MAC scheduler.
package eq_mac_sched_pkg;
    localparam int NUM_BANDS  = 5;
    localparam int BAND_SHIFT = 10;
    localparam int VOL_SHIFT  = 12;
    localparam logic signed [12:0] GAIN_OFS  = 13'sd2048;
    localparam logic signed [15:0] SAT16_MAX = 16'sh7fff;
    localparam logic signed [15:0] SAT16_MIN = 16'sh8000;
    typedef enum logic [1:0] {IDLE, BAND, VOL, DONE} state_t;
    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        return (x > 32'(SAT16_MAX)) ? SAT16_MAX : (x < 32'(SAT16_MIN)) ? SAT16_MIN : x[15:0];
    endfunction
    // Pot code 0x800 is zero gain, so the offset maps 0..4095 onto -2048..2047.
    function automatic logic signed [12:0] gain_of(input logic [11:0] pot);
        return $signed({1'b0, pot}) - GAIN_OFS;
    endfunction
endpackage

// File: rtl/eq_mac_sched_if.sv
// eq_mac_sched_if: sample/pot/result bundle between I2S side, band filters and spkr_drv.
//   master: drives vld, smp_in, gain_pots, vol_pot; slave (scheduler) drives the rest.
interface eq_mac_sched_if;
    logic                                          vld;
    logic [2:0]                                    band_sel;
    logic                                          chnl_sel;
    logic signed [15:0]                            smp_in;
    logic [12*eq_mac_sched_pkg::NUM_BANDS-1:0]     gain_pots;
    logic [11:0]                                   vol_pot;
    logic signed [15:0]                            aud_out_lft;
    logic signed [15:0]                            aud_out_rght;
    logic                                          rdy;
    logic                                          busy;
    logic                                          overrun;
    modport master (output vld, smp_in, gain_pots, vol_pot,
                    input band_sel, chnl_sel, aud_out_lft, aud_out_rght, rdy, busy, overrun);
    modport slave  (input vld, smp_in, gain_pots, vol_pot,
                    output band_sel, chnl_sel, aud_out_lft, aud_out_rght, rdy, busy, overrun);
endinterface

// File: rtl/eq_mac_sched_mac_unit.sv
// eq_mac_sched_mac_unit: shared signed 16x13 multiplier with a 32-bit accumulator.
//   i_clr/i_en control the accumulator, o_prod is the raw product,
//   o_band is the accumulator shifted by BAND_SHIFT and saturated to 16 bits.
module eq_mac_sched_mac_unit
    import eq_mac_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic signed [15:0] i_a,
    input  logic signed [12:0] i_b,
    output logic signed [28:0] o_prod,
    output logic signed [15:0] o_band
);
    logic signed [31:0] r_acc;
    assign o_prod = i_a * i_b;
    assign o_band = sat16(r_acc >>> BAND_SHIFT);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)     r_acc <= '0;
        else if (i_clr) r_acc <= '0;
        else if (i_en)  r_acc <= r_acc + 32'(o_prod);
endmodule

// File: rtl/eq_mac_sched.sv
// eq_mac_sched: sequences both channels' band-gain sums and volume products through one MAC.
//   clk, rst_n (async active-low); io: slave side of eq_mac_sched_if.
module eq_mac_sched
    import eq_mac_sched_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    eq_mac_sched_if.slave  io
);
    state_t                      r_state;
    logic [2:0]                  r_band;
    logic                        r_chnl;
    logic [12*NUM_BANDS-1:0]     r_pots;
    logic [11:0]                 r_vol;
    logic signed [15:0]          r_hold_l, r_hold_r, r_out_l, r_out_r;
    logic                        r_rdy, r_busy, r_ovr;
    logic                        w_vol_mode;
    logic signed [15:0]          w_a, w_band, w_v;
    logic signed [12:0]          w_b;
    logic signed [28:0]          w_prod;
    assign w_vol_mode = (r_state == VOL);
    // In VOL the multiplier is reused for the volume stage on the saturated band sum.
    assign w_a = w_vol_mode ? w_band : io.smp_in;
    assign w_b = w_vol_mode ? $signed({1'b0, r_vol}) : gain_of(r_pots[12*r_band +: 12]);
    assign w_v = sat16(32'(w_prod) >>> VOL_SHIFT);
    eq_mac_sched_mac_unit u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  ((r_state == IDLE && io.vld) || w_vol_mode),
        .i_en   (r_state == BAND),
        .i_a    (w_a),
        .i_b    (w_b),
        .o_prod (w_prod),
        .o_band (w_band)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_band   <= '0;
            r_chnl   <= 1'b0;
            r_pots   <= '0;
            r_vol    <= '0;
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_out_l  <= '0;
            r_out_r  <= '0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            r_ovr <= io.vld && r_busy;
            case (r_state)
                IDLE: if (io.vld) begin
                    r_busy  <= 1'b1;
                    r_pots  <= io.gain_pots;
                    r_vol   <= io.vol_pot;
                    r_state <= BAND;
                end
                BAND: begin
                    r_band  <= (r_band == 3'(NUM_BANDS-1)) ? 3'd0 : r_band + 3'd1;
                    r_state <= (r_band == 3'(NUM_BANDS-1)) ? VOL : BAND;
                end
                VOL: if (!r_chnl) begin
                    r_hold_l <= w_v;
                    r_chnl   <= 1'b1;
                    r_band   <= '0;
                    r_state  <= BAND;
                end else begin
                    r_hold_r <= w_v;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_out_l <= r_hold_l;
                    r_out_r <= r_hold_r;
                    r_rdy   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_chnl  <= 1'b0;
                    r_band  <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign io.band_sel     = r_band;
    assign io.chnl_sel     = r_chnl;
    assign io.aud_out_lft  = r_out_l;
    assign io.aud_out_rght = r_out_r;
    assign io.rdy          = r_rdy;
    assign io.busy         = r_busy;
    assign io.overrun      = r_ovr;
endmodule

// File: tb/tb_eq_mac_sched.sv
// tb_eq_mac_sched: table-driven frame checks plus overrun, snapshot and mid-frame reset sequences.
module tb_eq_mac_sched;
    logic clk, rst_n;
    int   n_chk = 0, n_fail = 0;
    bit   pat;
    logic signed [15:0] smp_l, smp_r;
    eq_mac_sched_if bus();
    eq_mac_sched dut (.clk(clk), .rst_n(rst_n), .io(bus));
    initial clk = 1'b0;
    always #10 clk = ~clk;
    // Pattern mode gives each band a distinct sample: +/-(band+1)*100, negative on the right.
    assign bus.smp_in = pat ? 16'((int'(bus.band_sel) + 1) * (bus.chnl_sel ? -100 : 100))
                            : (bus.chnl_sel ? smp_r : smp_l);
    typedef struct {
        string              nm;
        bit                 pat;
        logic signed [15:0] l, r;
        logic [59:0]        pots;
        logic [11:0]        vol;
        int                 el, er;
    } vec_t;
    vec_t vecs[9];
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic start(input vec_t v);
        pat = v.pat; smp_l = v.l; smp_r = v.r;
        bus.gain_pots = v.pots; bus.vol_pot = v.vol;
        @(negedge clk); bus.vld = 1'b1;
        @(posedge clk); #1 bus.vld = 1'b0;
    endtask
    task automatic run_frame(input vec_t v);
        int k; bit ok;
        k = 0; ok = 1'b1;
        start(v);
        @(negedge clk);
        while (!bus.rdy && k < 40) begin
            if (k < 5)              ok &= (int'(bus.band_sel) == k)     && !bus.chnl_sel;
            if (k >= 6 && k < 11)   ok &= (int'(bus.band_sel) == k - 6) &&  bus.chnl_sel;
            if (k < 13)             ok &= bus.busy;
            @(negedge clk); k++;
        end
        chk({v.nm, " latency"}, k, 13);
        chk({v.nm, " lft"}, int'(bus.aud_out_lft), v.el);
        chk({v.nm, " rght"}, int'(bus.aud_out_rght), v.er);
        chk({v.nm, " trace"}, int'(ok), 1);
        @(negedge clk);
        chk({v.nm, " rdy_pulse"}, int'(bus.rdy), 0);
    endtask
    task automatic seq(input string nm, input int vld_k, input int vol_k);
        int nr, rk, no, ok_k, b14;
        nr = 0; rk = -1; no = 0; ok_k = -1; b14 = -1;
        start(vecs[0]);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.rdy) begin nr++; if (rk < 0) rk = k; end
            if (bus.overrun) begin no++; if (ok_k < 0) ok_k = k; end
            if (k == 14) b14 = int'(bus.busy);
            if (k == vol_k) bus.vol_pot = 12'h000;
            bus.vld = (k == vld_k);
        end
        bus.vld = 1'b0;
        chk({nm, " overrun_cnt"}, no, 1);
        chk({nm, " overrun_cyc"}, ok_k, vld_k + 1);
        chk({nm, " rdy_cnt"}, nr, 1);
        chk({nm, " rdy_cyc"}, rk, 13);
        chk({nm, " lft"}, int'(bus.aud_out_lft), 4998);
        chk({nm, " idle_after"}, b14, 0);
    endtask
    initial begin
        vecs[0] = '{"unity",    0, 16'sd1000,   16'sd1000,  {5{12'hC00}}, 12'hFFF, 4998, 4998};
        vecs[1] = '{"neg",      0, -16'sd1000,  -16'sd1000, {5{12'hC00}}, 12'hFFF, -4999, -4999};
        vecs[2] = '{"sat_pos",  0, 16'sd32767,  16'sd32767, {5{12'hFFF}}, 12'hFFF, 32759, 32759};
        vecs[3] = '{"sat_neg",  0, -16'sd32768, -16'sd32768,{5{12'hFFF}}, 12'hFFF, -32760, -32760};
        vecs[4] = '{"zero_gain",0, 16'sd12345,  -16'sd777,  {5{12'h800}}, 12'hFFF, 0, 0};
        vecs[5] = '{"band2",    1, 16'sd0,      16'sd0,     {12'h800, 12'h800, 12'hC00, 12'h800, 12'h800}, 12'hFFF, 299, -300};
        vecs[6] = '{"mixed",    0, 16'sd1000,   -16'sd1000, {5{12'hC00}}, 12'hFFF, 4998, -4999};
        vecs[7] = '{"neg_gain", 0, 16'sd1000,   16'sd1000,  {5{12'h400}}, 12'hFFF, -4999, -4999};
        vecs[8] = '{"half_vol", 0, 16'sd1000,   16'sd1000,  {5{12'hC00}}, 12'h800, 2500, 2500};
        rst_n = 1'b0; bus.vld = 1'b0; pat = 1'b0; smp_l = '0; smp_r = '0;
        bus.gain_pots = '0; bus.vol_pot = '0;
        repeat (3) @(negedge clk);
        chk("rst lft", int'(bus.aud_out_lft), 0);
        chk("rst rght", int'(bus.aud_out_rght), 0);
        chk("rst flags", int'({bus.rdy, bus.busy, bus.overrun, bus.chnl_sel}), 0);
        chk("rst band_sel", int'(bus.band_sel), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) run_frame(vecs[i]);
        seq("ovr_mid", 5, 3);
        seq("ovr_done", 12, -1);
        start(vecs[1]);
        for (int k = 0; k < 8; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", int'(bus.busy), 0);
        chk("midrst lft", int'(bus.aud_out_lft), 0);
        chk("midrst rght", int'(bus.aud_out_rght), 0);
        chk("midrst rdy", int'(bus.rdy), 0);
        @(negedge clk); rst_n = 1'b1;
        begin
            int nr;
            nr = 0;
            for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.rdy) nr++; end
            chk("midrst no_rdy", nr, 0);
        end
        run_frame(vecs[6]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
